// File: rtl/demux_1_to_2_nbit_reg.sv
// rtl/demux_1_to_2_nbit_reg.sv - registered 1-to-2 demux into two valid/ready holding registers
// Each output is a single-entry skid-free register driven by its own EMPTY/FULL FSM.
module demux_1_to_2_nbit_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  select,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out0,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [CNT_WIDTH-1:0]  out0_count,
  output logic [CNT_WIDTH-1:0]  out1_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state0;
  state_t                r_state1;
  state_t                w_state0_nxt;
  state_t                w_state1_nxt;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;
  logic                  w_full0;
  logic                  w_full1;
  logic                  w_in_ready;
  logic                  w_wr0;
  logic                  w_wr1;

  assign w_full0 = (r_state0 == ST_FULL);
  assign w_full1 = (r_state1 == ST_FULL);

  // A full register can still accept when its consumer drains it this cycle.
  assign w_in_ready = select ? (!w_full1 || out1_ready) : (!w_full0 || out0_ready);

  assign w_wr0 = in_valid & w_in_ready & ~select;
  assign w_wr1 = in_valid & w_in_ready &  select;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state0 <= ST_EMPTY;
      r_state1 <= ST_EMPTY;
    end else begin
      r_state0 <= w_state0_nxt;
      r_state1 <= w_state1_nxt;
    end
  end

  always_comb begin
    w_state0_nxt = r_state0;
    case (r_state0)
      ST_EMPTY: if (w_wr0) w_state0_nxt = ST_FULL;
      ST_FULL:  if (!w_wr0 && out0_ready) w_state0_nxt = ST_EMPTY;
      default:  w_state0_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_state1_nxt = r_state1;
    case (r_state1)
      ST_EMPTY: if (w_wr1) w_state1_nxt = ST_FULL;
      ST_FULL:  if (!w_wr1 && out1_ready) w_state1_nxt = ST_EMPTY;
      default:  w_state1_nxt = ST_EMPTY;
    endcase
  end

  // Data is only loaded on a write, so an emptied register keeps its last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data0 <= '0;
      r_cnt0  <= '0;
    end else if (w_wr0) begin
      r_data0 <= in_data;
      r_cnt0  <= r_cnt0 + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data1 <= '0;
      r_cnt1  <= '0;
    end else if (w_wr1) begin
      r_data1 <= in_data;
      r_cnt1  <= r_cnt1 + CNT_WIDTH'(1);
    end
  end

  assign in_ready   = w_in_ready;
  assign out0       = r_data0;
  assign out1       = r_data1;
  assign out0_valid = w_full0;
  assign out1_valid = w_full1;
  assign out0_count = r_cnt0;
  assign out1_count = r_cnt1;

endmodule

// File: tb/tb_demux_1_to_2_nbit_reg.sv
// tb/tb_demux_1_to_2_nbit_reg.sv - scoreboard bench for the registered 1-to-2 demux
// Consumed words are checked by a negedge monitor against per-output expected queues.
module tb_demux_1_to_2_nbit_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        select;
  logic [31:0] in_data;
  logic [31:0] out0;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out1;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  out0_count;
  logic [7:0]  out1_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  demux_1_to_2_nbit_reg #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .select(select), .in_data(in_data),
    .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes on the next rising edge whenever valid & ready.
  always @(negedge clk) begin
    if (reset_n && out0_valid && out0_ready) begin
      if (exp0.size() == 0) begin
        n_total++;
        $display("FAIL out0_unexpected: got %h, expected no word", out0);
      end else check("out0_word", out0, exp0.pop_front());
    end
    if (reset_n && out1_valid && out1_ready) begin
      if (exp1.size() == 0) begin
        n_total++;
        $display("FAIL out1_unexpected: got %h, expected no word", out1);
      end else check("out1_word", out1, exp1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; select = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    step(); step();
    check("rst_out0_valid", 32'(out0_valid), 32'd0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out0", out0, 32'd0);
    check("rst_out1", out1, 32'd0);
    check("rst_out0_count", 32'(out0_count), 32'd0);
    check("rst_out1_count", 32'(out1_count), 32'd0);
    reset_n = 1'b1;
    step();

    // Route to out0 while consumer 0 is stalled
    select = 1'b0; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    #1 check("route_in_ready", 32'(in_ready), 32'd1);
    exp0.push_back(32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    check("route_out0", out0, 32'hDEADBEEF);
    check("route_out0_valid", 32'(out0_valid), 32'd1);
    check("route_out1_valid", 32'(out1_valid), 32'd0);
    check("route_out0_count", 32'(out0_count), 32'd1);

    // Backpressure on out0, then divert to out1
    select = 1'b0; in_data = 32'h00000BAD; in_valid = 1'b1;
    #1 check("bp_in_ready0", 32'(in_ready), 32'd0);
    step();
    check("bp_out0_held", out0, 32'hDEADBEEF);
    check("bp_out0_count", 32'(out0_count), 32'd1);
    select = 1'b1; in_data = 32'h12345678;
    #1 check("bp_in_ready1", 32'(in_ready), 32'd1);
    exp1.push_back(32'h12345678);
    step();
    in_valid = 1'b0;
    check("bp_out1", out1, 32'h12345678);
    check("bp_out1_valid", 32'(out1_valid), 32'd1);
    check("bp_out1_count", 32'(out1_count), 32'd1);
    check("bp_out0_still", out0, 32'hDEADBEEF);

    // Streaming 1..4 into out1 with consumer always ready
    out1_ready = 1'b1; select = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i); in_valid = 1'b1;
      #1 check("stream_in_ready", 32'(in_ready), 32'd1);
      exp1.push_back(32'(i));
      step();
      check("stream_out1", out1, 32'(i));
      check("stream_out1_valid", 32'(out1_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out1_ready = 1'b0;
    check("stream_drained", 32'(out1_valid), 32'd0);
    check("stream_hold_last", out1, 32'd4);
    check("stream_count", 32'(out1_count), 32'd5);

    // Consume A and write B to out0 in the same cycle
    select = 1'b0; out0_ready = 1'b1; in_data = 32'hBBBB0005; in_valid = 1'b1;
    #1 check("simul_in_ready", 32'(in_ready), 32'd1);
    exp0.push_back(32'hBBBB0005);
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    check("simul_out0", out0, 32'hBBBB0005);
    check("simul_out0_valid", 32'(out0_valid), 32'd1);
    check("simul_out0_count", 32'(out0_count), 32'd2);
    out0_ready = 1'b1;
    step();
    check("simul_drained", 32'(out0_valid), 32'd0);
    check("simul_hold_last", out0, 32'hBBBB0005);
    step();
    out0_ready = 1'b0;
    check("ready_on_empty", 32'(out0_valid), 32'd0);
    check("ready_on_empty_cnt", 32'(out0_count), 32'd2);

    // Write out0 while out1 drains its word
    select = 1'b1; in_data = 32'h00000077; in_valid = 1'b1;
    exp1.push_back(32'h00000077);
    step();
    select = 1'b0; in_data = 32'h00000055; out1_ready = 1'b1;
    exp0.push_back(32'h00000055);
    step();
    in_valid = 1'b0; out1_ready = 1'b0;
    check("indep_out0", out0, 32'h00000055);
    check("indep_out0_valid", 32'(out0_valid), 32'd1);
    check("indep_out1_valid", 32'(out1_valid), 32'd0);
    check("indep_out1_count", 32'(out1_count), 32'd6);
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;

    // Counter wrap on out1: 6 + 250 = 256 -> 0, then one more -> 1
    select = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      in_data = 32'(i + 1000); in_valid = 1'b1;
      exp1.push_back(32'(i + 1000));
      step();
    end
    check("wrap_out1_count0", 32'(out1_count), 32'd0);
    in_data = 32'hCAFE0001;
    exp1.push_back(32'hCAFE0001);
    step();
    in_valid = 1'b0;
    check("wrap_out1_count1", 32'(out1_count), 32'd1);
    check("wrap_out0_count", 32'(out0_count), 32'd3);
    step();
    out1_ready = 1'b0;

    // Asynchronous reset with both registers full
    select = 1'b0; in_data = 32'h000000A0; in_valid = 1'b1;
    step();
    select = 1'b1; in_data = 32'h000000A1;
    step();
    in_valid = 1'b0;
    check("pre_rst_out0_valid", 32'(out0_valid), 32'd1);
    check("pre_rst_out1_valid", 32'(out1_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out0_valid", 32'(out0_valid), 32'd0);
    check("arst_out1_valid", 32'(out1_valid), 32'd0);
    check("arst_out0", out0, 32'd0);
    check("arst_out1", out1, 32'd0);
    check("arst_out0_count", 32'(out0_count), 32'd0);
    check("arst_out1_count", 32'(out1_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Normal operation resumes after reset
    select = 1'b0; in_data = 32'h5A5A5A5A; in_valid = 1'b1; out0_ready = 1'b1;
    exp0.push_back(32'h5A5A5A5A);
    step();
    in_valid = 1'b0;
    check("post_rst_out0", out0, 32'h5A5A5A5A);
    check("post_rst_count", 32'(out0_count), 32'd1);
    step();
    out0_ready = 1'b0;
    step();
    check("exp0_empty", 32'(exp0.size()), 32'd0);
    check("exp1_empty", 32'(exp1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
